// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read address/data buses, the write port and
// the ready flag. The core side drives addresses and write data (master); the
// register file answers with read data and ready (slave).
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                ready;

    modport master (output ra, we, wa, wd, input rd, ready);
    modport slave  (input ra, we, wa, wd, output rd, ready);
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired-zero x0, optional
// same-cycle write-to-read bypass, and a post-reset sweep that zeroes every
// register before the file reports ready.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [XLEN-1:0]     mem_q [NREG];

    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [XLEN-1:0]     mem_wd;
    logic                run_active;
    logic [NRD*XLEN-1:0] rd_flat;

    // Contents are only exposed once the sweep has finished and reset is high.
    assign run_active = rst && (state_q == RUN);

    // Sweep/run sequencing and selection of the single storage write port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
        mem_wa  = bus.wa;
        mem_wd  = bus.wd;
        case (state_q)
            CLEAR: begin
                // Sweep owns the write port; external writes are dropped.
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = '0;
                if (ptr_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RUN: begin
                // x0 is never written, so its slot never needs to be trusted.
                mem_we = bus.we && (bus.wa != '0);
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
        // Reset edge: restart the sweep and write nothing.
        if (!rst) begin
            state_d = CLEAR;
            ptr_d   = '0;
            mem_we  = 1'b0;
        end
    end

    // State and sweep pointer registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
    end

    // Register storage; no reset, the sweep provides the clean state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Independent combinational read ports.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] ra_g;
        logic          hit_g;
        assign ra_g  = bus.ra[gi*AW +: AW];
        assign hit_g = (BYPASS != 0) && bus.we && (bus.wa == ra_g);
        assign rd_flat[gi*XLEN +: XLEN] = !run_active   ? '0 :
                                          (ra_g == '0)  ? '0 :
                                          hit_g         ? bus.wd :
                                                          mem_q[ra_g];
    end

    assign bus.rd    = rd_flat;
    assign bus.ready = run_active;

endmodule
